// File: rtl/cmd_encoder_pkg.sv
// Shared constants and types for the calculator command frame.
// The receive-side decoder imports the same package, so field positions live here only.
package cmd_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         FRAME_LEN = 8;

   localparam logic [2:0] IDX_SYNC    = 3'd0;
   localparam logic [2:0] IDX_OPER    = 3'd1;
   localparam logic [2:0] IDX_DTYPE   = 3'd2;
   localparam logic [2:0] IDX_SRC1_HI = 3'd3;
   localparam logic [2:0] IDX_SRC1_LO = 3'd4;
   localparam logic [2:0] IDX_SRC2_HI = 3'd5;
   localparam logic [2:0] IDX_SRC2_LO = 3'd6;
   localparam logic [2:0] IDX_CSUM    = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [FRAME_LEN-1:0][7:0] frame_t;

   // Checksum covers the payload bytes only; the sync byte is left out.
   function automatic frame_t build_frame(
      input logic [7:0]  sync,
      input logic [3:0]  dtype,
      input logic [4:0]  oper,
      input logic [15:0] src1,
      input logic [15:0] src2
   );
      frame_t f;
      f              = '0;
      f[IDX_SYNC]    = sync;
      f[IDX_OPER]    = {3'b000, oper};
      f[IDX_DTYPE]   = {4'h0, dtype};
      f[IDX_SRC1_HI] = src1[15:8];
      f[IDX_SRC1_LO] = src1[7:0];
      f[IDX_SRC2_HI] = src2[15:8];
      f[IDX_SRC2_LO] = src2[7:0];
      f[IDX_CSUM]    = f[IDX_OPER] ^ f[IDX_DTYPE] ^ f[IDX_SRC1_HI] ^
                       f[IDX_SRC1_LO] ^ f[IDX_SRC2_HI] ^ f[IDX_SRC2_LO];
      return f;
   endfunction

endpackage

// File: rtl/cmd_encoder_if.sv
// Command handshake plus byte stream toward the UART transmitter.
// master = command source / byte sink, slave = the encoder.
interface cmd_encoder_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  dtype;
   logic [4:0]  operator;
   logic [15:0] src1;
   logic [15:0] src2;
   logic [7:0]  tx_data;
   logic        uout_valid;
   logic        tx_ready;

   modport master (
      output cmd_valid, dtype, operator, src1, src2, tx_ready,
      input  cmd_ready, tx_data, uout_valid
   );

   modport slave (
      input  cmd_valid, dtype, operator, src1, src2, tx_ready,
      output cmd_ready, tx_data, uout_valid
   );

endinterface

// File: rtl/cmd_encoder.sv
// Serializes one calculator command into an 8-byte checksummed frame.
// Single FSM; all outputs come straight from registers.
module cmd_encoder
   import cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = cmd_pkg::SYNC_BYTE,
   parameter int         FRAME_LEN = cmd_pkg::FRAME_LEN
) (
   input  logic        clk,
   input  logic        n_rst,
   cmd_encoder_if.slave bus,
   output logic        frame_done,
   output logic [7:0]  frame_cnt
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

   state_t                     state_reg;
   logic [2:0]                 idx_reg;
   logic [FRAME_LEN-1:0][7:0]  frame_reg;
   logic [FRAME_LEN-1:0][7:0]  frame_next;
   logic [7:0]                 tx_data_reg;
   logic                       uout_valid_reg;
   logic                       cmd_ready_reg;
   logic                       frame_done_reg;
   logic [7:0]                 frame_cnt_reg;

   assign frame_next = build_frame(SYNC_BYTE, bus.dtype, bus.operator, bus.src1, bus.src2);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         frame_reg      <= '0;
         tx_data_reg    <= '0;
         uout_valid_reg <= 1'b0;
         cmd_ready_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               frame_done_reg <= 1'b0;
               if (bus.cmd_valid && cmd_ready_reg) begin
                  // Snapshot the whole frame so later input changes cannot leak in.
                  frame_reg      <= frame_next;
                  idx_reg        <= '0;
                  tx_data_reg    <= SYNC_BYTE;
                  uout_valid_reg <= 1'b1;
                  cmd_ready_reg  <= 1'b0;
                  state_reg      <= SEND;
               end else begin
                  cmd_ready_reg  <= 1'b1;
               end
            end
            SEND: begin
               if (bus.tx_ready) begin
                  if (idx_reg == LAST_IDX) begin
                     uout_valid_reg <= 1'b0;
                     frame_done_reg <= 1'b1;
                     frame_cnt_reg  <= frame_cnt_reg + 8'd1;
                     state_reg      <= DONE;
                  end else begin
                     idx_reg        <= idx_reg + 3'd1;
                     tx_data_reg    <= frame_reg[idx_reg + 3'd1];
                  end
               end
            end
            DONE: begin
               frame_done_reg <= 1'b0;
               cmd_ready_reg  <= 1'b1;
               state_reg      <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_reg;
   assign bus.tx_data    = tx_data_reg;
   assign bus.uout_valid = uout_valid_reg;
   assign frame_done     = frame_done_reg;
   assign frame_cnt      = frame_cnt_reg;

endmodule
